// File: rtl/syn_ram_pkg.sv
// syn_ram_pkg: shared types and helpers for the syn_ram_2p dual-port RAM
package syn_ram_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {CLEAR, READY} state_e;
  function automatic logic byte_parity(input logic [BYTE_W-1:0] data);
    return ^data;
  endfunction
endpackage

// File: rtl/syn_ram_init_seq.sv
// syn_ram_init_seq: post-reset clear sweep FSM; muxes the sweep onto the array write port
module syn_ram_init_seq
  import syn_ram_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  localparam int NBYTES = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [NBYTES-1:0] wbe_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [NBYTES-1:0] mem_be_o,
  output logic              init_busy_o
);
  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else if (state_q == CLEAR) begin
      clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
      if (&clr_ptr_q) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  end
  // The sweep owns the write port while busy; user writes are dropped
  assign mem_we_o    = busy_q | we_i;
  assign mem_addr_o  = busy_q ? clr_ptr_q : waddr_i;
  assign mem_data_o  = busy_q ? '0 : wdata_i;
  assign mem_be_o    = busy_q ? '1 : wbe_i;
  assign init_busy_o = busy_q;
endmodule

// File: rtl/syn_ram_2p.sv
// syn_ram_2p: simple-dual-port RAM, byte enables, registered write-first read, clear sweep.
// Optional per-lane even parity when SYN_RAM_PARITY_EN is defined.
module syn_ram_2p
  import syn_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  localparam int NBYTES = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [NBYTES-1:0] wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_busy,
  input  logic              par_inject,
  output logic              parity_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NBYTES-1:0] w_be;
  syn_ram_init_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_init (
    .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .mem_we_o(w_en), .mem_addr_o(w_addr), .mem_data_o(w_data), .mem_be_o(w_be),
    .init_busy_o(init_busy)
  );
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++)
      if (w_en && w_be[i]) mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
  end
  logic              rd_en, hit;
  logic [DATA_W-1:0] byp, rdata_d, rdata_q;
  logic              rvalid_q, perr_d, perr_q;
  assign rd_en = re & ~init_busy;
  assign hit   = we & rd_en & (waddr == raddr);
  // Write-first bypass is resolved per lane
  always_comb begin
    byp = mem[raddr];
    for (int i = 0; i < NBYTES; i++)
      if (hit && wbe[i]) byp[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
    rdata_d = rd_en ? byp : rdata_q;
  end
`ifdef SYN_RAM_PARITY_EN
  logic [NBYTES-1:0] par_mem [DEPTH];
  logic [NBYTES-1:0] w_par, rd_par;
  logic              mism;
  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < NBYTES; i++)
      w_par[i] = byte_parity(w_data[i*BYTE_W +: BYTE_W]) ^ (par_inject & ~init_busy);
    rd_par = par_mem[raddr];
    for (int i = 0; i < NBYTES; i++) begin
      if (hit && wbe[i]) rd_par[i] = w_par[i];
      mism = mism | (byte_parity(byp[i*BYTE_W +: BYTE_W]) ^ rd_par[i]);
    end
    perr_d = rd_en & mism;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++)
      if (w_en && w_be[i]) par_mem[w_addr][i] <= w_par[i];
  end
`else
  logic unused_par;
  assign unused_par = par_inject;
  assign perr_d     = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_en;
      perr_q   <= perr_d;
    end
  end
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign parity_err = perr_q;
endmodule

// File: tb/tb_syn_ram_2p.sv
// tb_syn_ram_2p: directed vectors plus per-cycle comparison against a behavioural RAM model
module tb_syn_ram_2p;
  localparam int DW = 16, AW = 4, NB = 2, DEPTH = 16;
`ifdef SYN_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic          clk = 1'b0, rst_n = 1'b0, we = 1'b0, re = 1'b0, par_inject = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wbe = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, init_busy, parity_err;
  always #5 clk = ~clk;
  syn_ram_2p #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .init_busy(init_busy),
    .par_inject(par_inject), .parity_err(parity_err)
  );
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: words, a per-lane "parity was corrupted" flag, and a count of cleared words
  logic [DW-1:0] m_mem [DEPTH];
  logic [NB-1:0] m_flip [DEPTH];
  int            cleared = 0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_rvalid = 1'b0, e_perr = 1'b0;
  bit            m_on = 1'b0;
  always @(posedge clk) begin
    m_on = 1'b1;
    if (!rst_n) begin
      cleared = 0; e_rdata = '0; e_rvalid = 1'b0; e_perr = 1'b0;
    end else if (cleared < DEPTH) begin
      m_mem[cleared] = '0; m_flip[cleared] = '0; cleared++;
      e_rvalid = 1'b0; e_perr = 1'b0;
    end else begin
      e_rvalid = re; e_perr = 1'b0;
      if (re)
        for (int i = 0; i < NB; i++) begin
          bit b;
          b = we && waddr == raddr && wbe[i];
          e_rdata[8*i +: 8] = b ? wdata[8*i +: 8] : m_mem[raddr][8*i +: 8];
          if (PAR && (b ? par_inject : m_flip[raddr][i])) e_perr = 1'b1;
        end
      if (we)
        for (int i = 0; i < NB; i++)
          if (wbe[i]) begin
            m_mem[waddr][8*i +: 8] = wdata[8*i +: 8];
            m_flip[waddr][i] = par_inject;
          end
    end
  end
  always @(negedge clk) if (m_on) begin
    chk("init_busy", 32'(init_busy), 32'(cleared < DEPTH));
    chk("rvalid", 32'(rvalid), 32'(e_rvalid));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("parity_err", 32'(parity_err), 32'(e_perr));
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be, input logic inj);
    we = 1'b1; waddr = a; wdata = d; wbe = be; par_inject = inj;
    cyc();
    we = 1'b0; par_inject = 1'b0;
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    re = 1'b1; raddr = a;
    cyc();
    re = 1'b0;
    chk(nm, 32'(rdata), 32'(exp));
    chk({nm, "_valid"}, 32'(rvalid), 32'd1);
  endtask
  task automatic wr_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be,
                       input logic inj, input logic [DW-1:0] exp, input string nm);
    we = 1'b1; waddr = a; wdata = d; wbe = be; par_inject = inj; re = 1'b1; raddr = a;
    cyc();
    we = 1'b0; re = 1'b0; par_inject = 1'b0;
    chk(nm, 32'(rdata), 32'(exp));
  endtask
  // Counts busy cycles after reset release; a stray write+read to addr 9 is issued late in the sweep
  task automatic sweep_count(output int n);
    n = init_busy ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      if (n == 12) begin
        we = 1'b1; waddr = 4'd9; wdata = 16'h1234; wbe = 2'b11; re = 1'b1; raddr = 4'd9;
      end
      cyc();
      we = 1'b0; re = 1'b0;
      if (!init_busy) break;
      n++;
    end
  endtask
  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) cyc();
    chk("reset_busy", 32'(init_busy), 32'd1);
    chk("reset_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    sweep_count(n);
    chk("sweep_len", 32'(n), 32'd16);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), 16'h0000, "clr_rd");
    wr(4'd3, 16'h00A5, 2'b11, 1'b0);
    rd(4'd3, 16'h00A5, "rd_a5");
    cyc();
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("rdata_hold", 32'(rdata), 32'h00A5);
    wr(4'd2, 16'h1234, 2'b11, 1'b0);
    wr(4'd2, 16'hABCD, 2'b01, 1'b0);
    rd(4'd2, 16'h12CD, "rd_bytelane");
    wr(4'd5, 16'h5577, 2'b11, 1'b0);
    wr_rd(4'd5, 16'h113C, 2'b01, 1'b0, 16'h553C, "byp_lo");
    wr_rd(4'd5, 16'h9999, 2'b00, 1'b0, 16'h553C, "byp_none");
    wr_rd(4'd5, 16'hEE00, 2'b10, 1'b0, 16'hEE3C, "byp_hi");
    we = 1'b1; waddr = 4'd6; wdata = 16'hFFFF; wbe = 2'b11; re = 1'b1; raddr = 4'd5;
    cyc();
    we = 1'b0; re = 1'b0;
    chk("indep_rd", 32'(rdata), 32'hEE3C);
    rd(4'd6, 16'hFFFF, "indep_wr");
    wr(4'd9, 16'hBEEF, 2'b11, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (7) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    sweep_count(n);
    chk("resweep_len", 32'(n), 32'd16);
    rd(4'd9, 16'h0000, "rd_9_cleared");
    rd(4'd3, 16'h0000, "rd_3_cleared");
    wr(4'd1, 16'h000F, 2'b01, 1'b1);
    rd(4'd1, 16'h000F, "rd_inj");
    chk("perr_inj", 32'(parity_err), 32'(PAR));
    wr(4'd1, 16'h000F, 2'b01, 1'b0);
    rd(4'd1, 16'h000F, "rd_clean");
    chk("perr_clean", 32'(parity_err), 32'd0);
    wr_rd(4'd1, 16'h0F0F, 2'b10, 1'b1, 16'h0F0F, "byp_inj");
    chk("perr_byp", 32'(parity_err), 32'(PAR));
    cyc();
    chk("perr_drop", 32'(parity_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
